// File: rtl/add_arbiter.sv
// Round-robin sharing of one pipelined FP adder between two requesters, with
// row/source tagging of results and a level-sensitive flush/drain handshake.
module add_arbiter #(
   parameter int DATA_W  = 64,
   parameter int ROW_W   = 10,
   parameter int ADD_LAT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [ROW_W-1:0]  req0_row,
   input  logic              req1,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [ROW_W-1:0]  req1_row,
   output logic              gnt0,
   output logic              gnt1,
   output logic              add,
   output logic [DATA_W-1:0] add0,
   output logic [DATA_W-1:0] add1,
   output logic [ROW_W-1:0]  add_row,
   input  logic [DATA_W-1:0] sum,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_value,
   output logic [ROW_W-1:0]  res_row,
   output logic              res_src,
   input  logic              flush,
   output logic              flush_done
);

   localparam int CNT_W = $clog2(ADD_LAT + 2) + 1;

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   state_t             state_q, state_d;
   logic               last_q, last_d;
   logic               add_q, add_d;
   logic [DATA_W-1:0]  add0_q, add0_d;
   logic [DATA_W-1:0]  add1_q, add1_d;
   logic [ROW_W-1:0]   add_row_q, add_row_d;
   logic               add_src_q, add_src_d;
   logic [ADD_LAT-1:0] tag_valid_q, tag_valid_d;
   logic [ADD_LAT-1:0] tag_src_q, tag_src_d;
   logic [ROW_W-1:0]   tag_row_q [ADD_LAT];
   logic [ROW_W-1:0]   tag_row_d [ADD_LAT];
   logic               res_valid_q, res_valid_d;
   logic [DATA_W-1:0]  res_value_q, res_value_d;
   logic [ROW_W-1:0]   res_row_q, res_row_d;
   logic               res_src_q, res_src_d;
   logic [CNT_W-1:0]   inflight_q, inflight_d;

   // Grants are masked during reset so nothing transfers while the block is held.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset && !flush && state_q == RUN) begin
         if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = !last_q;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   always_comb begin
      last_d    = last_q;
      add_d     = gnt0 | gnt1;
      add0_d    = add0_q;
      add1_d    = add1_q;
      add_row_d = add_row_q;
      add_src_d = add_src_q;
      if (gnt0) begin
         last_d    = 1'b0;
         add0_d    = req0_a;
         add1_d    = req0_b;
         add_row_d = req0_row;
         add_src_d = 1'b0;
      end else if (gnt1) begin
         last_d    = 1'b1;
         add0_d    = req1_a;
         add1_d    = req1_b;
         add_row_d = req1_row;
         add_src_d = 1'b1;
      end
   end

   // Tag pipe tracks the adder so the tail lines up with the cycle sum is valid.
   always_comb begin
      tag_valid_d[0] = add_q;
      tag_src_d[0]   = add_src_q;
      tag_row_d[0]   = add_row_q;
      for (int i = 1; i < ADD_LAT; i++) begin
         tag_valid_d[i] = tag_valid_q[i-1];
         tag_src_d[i]   = tag_src_q[i-1];
         tag_row_d[i]   = tag_row_q[i-1];
      end
   end

   always_comb begin
      res_valid_d = tag_valid_q[ADD_LAT-1];
      res_value_d = res_value_q;
      res_row_d   = res_row_q;
      res_src_d   = res_src_q;
      if (tag_valid_q[ADD_LAT-1]) begin
         res_value_d = sum;
         res_row_d   = tag_row_q[ADD_LAT-1];
         res_src_d   = tag_src_q[ADD_LAT-1];
      end
   end

   always_comb begin
      inflight_d = inflight_q + CNT_W'(add_q) - CNT_W'(res_valid_q);
   end

   // Drain completes once the count after this cycle's retirement reaches zero.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (flush) state_d = DRAIN;
         DRAIN:   if (inflight_d == '0 && !add_q) state_d = DONE;
         DONE:    if (!flush) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= RUN;
         last_q      <= 1'b1;
         add_q       <= 1'b0;
         add0_q      <= '0;
         add1_q      <= '0;
         add_row_q   <= '0;
         add_src_q   <= 1'b0;
         tag_valid_q <= '0;
         tag_src_q   <= '0;
         for (int i = 0; i < ADD_LAT; i++) tag_row_q[i] <= '0;
         res_valid_q <= 1'b0;
         res_value_q <= '0;
         res_row_q   <= '0;
         res_src_q   <= 1'b0;
         inflight_q  <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         add_q       <= add_d;
         add0_q      <= add0_d;
         add1_q      <= add1_d;
         add_row_q   <= add_row_d;
         add_src_q   <= add_src_d;
         tag_valid_q <= tag_valid_d;
         tag_src_q   <= tag_src_d;
         for (int i = 0; i < ADD_LAT; i++) tag_row_q[i] <= tag_row_d[i];
         res_valid_q <= res_valid_d;
         res_value_q <= res_value_d;
         res_row_q   <= res_row_d;
         res_src_q   <= res_src_d;
         inflight_q  <= inflight_d;
      end
   end

   assign add        = add_q;
   assign add0       = add0_q;
   assign add1       = add1_q;
   assign add_row    = add_row_q;
   assign res_valid  = res_valid_q;
   assign res_value  = res_value_q;
   assign res_row    = res_row_q;
   assign res_src    = res_src_q;
   assign flush_done = (state_q == DONE);

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: transaction-queue reference model checked every cycle,
// plus directed scenarios with hand-computed timing and values.
module tb_add_arbiter;

   localparam int DATA_W  = 64;
   localparam int ROW_W   = 10;
   localparam int ADD_LAT = 4;
   localparam int M_RUN   = 0;
   localparam int M_DRAIN = 1;
   localparam int M_DONE  = 2;
   localparam logic [63:0] FP_ONE   = 64'h3FF0000000000000;
   localparam logic [63:0] FP_TWO   = 64'h4000000000000000;
   localparam logic [63:0] FP_THREE = 64'h4008000000000000;

   logic              clk = 1'b0;
   logic              reset;
   logic              req0, req1, flush;
   logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic [ROW_W-1:0]  req0_row, req1_row;
   logic              gnt0, gnt1, add, res_valid, res_src, flush_done;
   logic [DATA_W-1:0] add0, add1, res_value;
   logic [ROW_W-1:0]  add_row, res_row;
   logic [DATA_W-1:0] sum = '0;

   add_arbiter #(.DATA_W(DATA_W), .ROW_W(ROW_W), .ADD_LAT(ADD_LAT)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req0_a(req0_a), .req0_b(req0_b), .req0_row(req0_row),
      .req1(req1), .req1_a(req1_a), .req1_b(req1_b), .req1_row(req1_row),
      .gnt0(gnt0), .gnt1(gnt1), .add(add), .add0(add0), .add1(add1), .add_row(add_row),
      .sum(sum), .res_valid(res_valid), .res_value(res_value), .res_row(res_row),
      .res_src(res_src), .flush(flush), .flush_done(flush_done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [ROW_W-1:0]  row;
      logic              src;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      int                res_cyc;
   } txn_t;

   txn_t              pend[$];
   int                m_last, m_mode;
   logic              e_g0, e_g1, e_add, e_rv, e_rsrc;
   logic [DATA_W-1:0] e_add0, e_add1, e_rval;
   logic [ROW_W-1:0]  e_add_row, e_rrow;
   logic [DATA_W-1:0] apipe [ADD_LAT+1];

   function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b);
      return $realtobits($bitstoreal(a) + $bitstoreal(b));
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      m_last    = 1;
      m_mode    = M_RUN;
      e_add     = 1'b0;
      e_add0    = '0;
      e_add1    = '0;
      e_add_row = '0;
      e_rv      = 1'b0;
      e_rval    = '0;
      e_rrow    = '0;
      e_rsrc    = 1'b0;
   endtask

   // Advance the model across the clock edge that ends the current cycle.
   task automatic model_step();
      txn_t t;
      bit   drained;
      drained = (pend.size() == 0);
      if (pend.size() > 0 && pend[0].res_cyc == cyc + 1) begin
         e_rv   = 1'b1;
         e_rval = fp_add(pend[0].a, pend[0].b);
         e_rrow = pend[0].row;
         e_rsrc = pend[0].src;
         void'(pend.pop_front());
      end else begin
         e_rv = 1'b0;
      end
      case (m_mode)
         M_RUN:   if (flush) m_mode = M_DRAIN;
         M_DRAIN: if (drained) m_mode = M_DONE;
         default: if (!flush) m_mode = M_RUN;
      endcase
      e_add = e_g0 | e_g1;
      if (e_g0 || e_g1) begin
         t.src     = e_g1;
         t.row     = e_g1 ? req1_row : req0_row;
         t.a       = e_g1 ? req1_a : req0_a;
         t.b       = e_g1 ? req1_b : req0_b;
         t.res_cyc = cyc + 2 + ADD_LAT;
         pend.push_back(t);
         e_add0    = t.a;
         e_add1    = t.b;
         e_add_row = t.row;
         m_last    = e_g1 ? 1 : 0;
      end
   endtask

   initial model_reset();

   always @(negedge clk) begin
      if (!reset) model_reset();
      e_g0 = 1'b0;
      e_g1 = 1'b0;
      if (reset && !flush && m_mode == M_RUN) begin
         if (req0 && req1) begin
            e_g0 = (m_last == 1);
            e_g1 = (m_last != 1);
         end else begin
            e_g0 = req0;
            e_g1 = req1;
         end
      end
      checkOutput("gnt0", gnt0, e_g0);
      checkOutput("gnt1", gnt1, e_g1);
      checkOutput("add", add, e_add);
      checkOutput("add0", add0, e_add0);
      checkOutput("add1", add1, e_add1);
      checkOutput("add_row", add_row, e_add_row);
      checkOutput("res_valid", res_valid, e_rv);
      checkOutput("flush_done", flush_done, m_mode == M_DONE);
      if (e_rv || !reset) begin
         checkOutput("res_value", res_value, e_rval);
         checkOutput("res_row", res_row, e_rrow);
         checkOutput("res_src", res_src, e_rsrc);
      end
      if (reset) model_step();
      for (int i = ADD_LAT; i > 0; i--) apipe[i] = apipe[i-1];
      apipe[0] = add ? fp_add(add0, add1) : 64'hDEADBEEF0BADF00D;
      sum = apipe[ADD_LAT];
      cyc++;
   end

   task automatic applyStimulus(input logic r0, input logic [63:0] a0, input logic [63:0] b0,
                                input logic [ROW_W-1:0] row0, input logic r1,
                                input logic [63:0] a1, input logic [63:0] b1,
                                input logic [ROW_W-1:0] row1, input logic fl);
      @(posedge clk);
      #1;
      req0 = r0; req0_a = a0; req0_b = b0; req0_row = row0;
      req1 = r1; req1_a = a1; req1_b = b1; req1_row = row1;
      flush = fl;
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(0, '0, '0, '0, 0, '0, '0, '0, 0);
   endtask

   task automatic flushPulseCheck(input string tag);
      applyStimulus(0, '0, '0, '0, 0, '0, '0, '0, 1);
      @(negedge clk) checkOutput({tag, "_t0"}, flush_done, 0);
      applyStimulus(0, '0, '0, '0, 0, '0, '0, '0, 0);
      @(negedge clk) checkOutput({tag, "_t1"}, flush_done, 0);
      applyStimulus(0, '0, '0, '0, 0, '0, '0, '0, 0);
      @(negedge clk) checkOutput({tag, "_t2"}, flush_done, 1);
      applyStimulus(0, '0, '0, '0, 0, '0, '0, '0, 0);
      @(negedge clk) checkOutput({tag, "_t3"}, flush_done, 0);
   endtask

   initial begin
      int          lat, nres, last_rv, done_at, ngnt, n0, n1;
      logic [5:0]  gpat, spat;

      reset = 1'b0; flush = 1'b0;
      req0 = 1'b1; req0_a = FP_ONE; req0_b = FP_TWO; req0_row = 10'd7;
      req1 = 1'b1; req1_a = FP_TWO; req1_b = FP_TWO; req1_row = 10'd8;
      repeat (3) @(negedge clk);
      checkOutput("rst_gnt0", gnt0, 0);
      checkOutput("rst_gnt1", gnt1, 0);
      checkOutput("rst_add", add, 0);
      checkOutput("rst_res_valid", res_valid, 0);
      checkOutput("rst_flush_done", flush_done, 0);

      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checkOutput("first_gnt0", gnt0, 1);
      checkOutput("first_gnt1", gnt1, 0);
      applyStimulus(0, '0, '0, '0, 1, FP_TWO, FP_TWO, 10'd8, 0);
      idle(10);

      applyStimulus(1, FP_ONE, FP_TWO, 10'd5, 0, '0, '0, '0, 0);
      @(negedge clk) checkOutput("single_gnt0", gnt0, 1);
      idle(1);
      @(negedge clk);
      checkOutput("single_add", add, 1);
      checkOutput("single_add0", add0, FP_ONE);
      checkOutput("single_add1", add1, FP_TWO);
      checkOutput("single_add_row", add_row, 10'd5);
      lat = 0;
      for (int k = 2; k <= 12 && lat == 0; k++) begin
         idle(1);
         @(negedge clk);
         if (res_valid) begin
            lat = k;
            checkOutput("single_value", res_value, FP_THREE);
            checkOutput("single_row", res_row, 10'd5);
            checkOutput("single_src", res_src, 0);
         end
      end
      checkOutput("single_latency", lat, 6);

      applyStimulus(0, '0, '0, '0, 1, $realtobits(0.5), $realtobits(0.25), 10'd9, 0);
      idle(10);

      n0 = 0; n1 = 0; gpat = '0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, $realtobits(real'(n0 + 1)), $realtobits(1.5), 10'(16 + n0),
                       1, $realtobits(real'(10 * n1)), $realtobits(0.75), 10'(32 + n1), 0);
         @(negedge clk);
         gpat[i] = gnt1;
         if (gnt0) n0++;
         if (gnt1) n1++;
      end
      checkOutput("contend_grants", gpat, 6'b101010);
      nres = 0; spat = '0;
      for (int k = 0; k < 14; k++) begin
         idle(1);
         @(negedge clk);
         if (res_valid && nres < 6) begin
            spat[nres] = res_src;
            nres++;
         end
      end
      checkOutput("contend_count", nres, 6);
      checkOutput("contend_srcs", spat, 6'b101010);

      for (int i = 0; i < 3; i++)
         applyStimulus(1, $realtobits(real'(i)), FP_ONE, 10'(40 + i), 0, '0, '0, '0, 0);
      nres = 0; last_rv = -1; done_at = -1; ngnt = 0;
      for (int k = 0; k < 20 && done_at < 0; k++) begin
         applyStimulus(1, FP_ONE, FP_ONE, 10'd43, 1, FP_TWO, FP_ONE, 10'd60, 1);
         @(negedge clk);
         if (gnt0 || gnt1) ngnt++;
         if (res_valid) begin
            nres++;
            last_rv = k;
         end
         if (flush_done) done_at = k;
      end
      checkOutput("drain_grants", ngnt, 0);
      checkOutput("drain_results", nres, 3);
      checkOutput("drain_last_res", last_rv, 5);
      checkOutput("drain_done_cyc", done_at, 6);
      applyStimulus(1, FP_ONE, FP_ONE, 10'd43, 1, FP_TWO, FP_ONE, 10'd60, 0);
      @(negedge clk) checkOutput("resume_hold", gnt0 | gnt1, 0);
      applyStimulus(1, FP_ONE, FP_ONE, 10'd43, 1, FP_TWO, FP_ONE, 10'd60, 0);
      @(negedge clk) checkOutput("resume_gnt1", gnt1, 1);
      idle(10);

      flushPulseCheck("idle_flush");
      idle(2);

      applyStimulus(1, FP_TWO, FP_TWO, 10'd50, 0, '0, '0, '0, 0);
      applyStimulus(1, FP_ONE, FP_TWO, 10'd51, 0, '0, '0, '0, 0);
      applyStimulus(0, '0, '0, '0, 0, '0, '0, '0, 1);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      checkOutput("async_add", add, 0);
      checkOutput("async_add0", add0, 0);
      checkOutput("async_add_row", add_row, 0);
      checkOutput("async_res_valid", res_valid, 0);
      flush = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      nres = 0;
      for (int k = 0; k < 12; k++) begin
         idle(1);
         @(negedge clk);
         if (res_valid) nres++;
      end
      checkOutput("post_reset_results", nres, 0);
      applyStimulus(1, FP_ONE, FP_ONE, 10'd3, 0, '0, '0, '0, 0);
      @(negedge clk) checkOutput("post_reset_gnt0", gnt0, 1);
      idle(10);
      flushPulseCheck("post_reset_flush");
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Shares the single pipelined floating-point adder of the row intermediator between two requesters: the intermediator's own merge path and the drain/reduction path. It round-robins requests and registers operands onto the adder inputs. It tags each issue with row and source so the adder result returns with its identity. A level-sensitive flush stops issue, drains all in-flight additions, and reports completion.

## Interface
- DATA_W, 64, operand/result width
- ROW_W, 10, row tag width
- ADD_LAT, 4, fixed adder latency in cycles from `add` high to `sum` valid (≥1)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- req0 / req1  in  1  requester 0/1 has a pending addition
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands; held stable while req high and not granted
- req0_row / req1_row  in  ROW_W  row tag of the request
- gnt0 / gnt1  out  1  combinational grant; transfer occurs when reqN & gntN
- add  out  1  registered issue strobe to adder
- add0, add1  out  DATA_W  registered adder operands
- add_row  out  ROW_W  registered row of issued addition
- sum  in  DATA_W  adder result, valid ADD_LAT cycles after `add`
- res_valid  out  1  registered result strobe
- res_value  out  DATA_W  registered result
- res_row  out  ROW_W  row tag of result
- res_src  out  1  requester index that issued it
- flush  in  1  level request to stop issue and drain
- flush_done  out  1  high while drained and flush still high

## Operation
- Arbitration: pointer `last` (reset 1). One request → grant it. Both → grant !last. `last` ← granted index on each grant; unchanged otherwise. At most one grant per cycle.
- Grants forced 0 when flush=1 or state≠RUN.
- Issue: on grant, next cycle add=1, add0/add1/add_row = granted operands/row; else add=0, operands hold previous values.
- Tag pipe: ADD_LAT-deep shift of {valid, row, src} fed by the issue register. At the tail, when valid: res_valid=1 next cycle, res_value=sum, res_row/res_src from tag.
- In-flight counter `inflight` (width clog2(ADD_LAT+2)+1): +1 when add=1, −1 when res_valid=1, unchanged when both. Max ADD_LAT+1; never underflows.
- FSM:
  - RUN: flush=1 → DRAIN.
  - DRAIN: inflight=0 and add=0 → DONE.
  - DONE: flush_done=1; flush=0 → RUN.
  - DRAIN with flush dropped before empty: continue to DONE, then RUN next cycle (flush_done pulses one cycle).
- Reset (any time, incl. mid-drain): all in-flight tags discarded; results in the adder are never reported.

## Timing
- Reset values: gnt0=gnt1=0, add=0, add0=add1=0, add_row=0, res_valid=0, res_value=0, res_row=0, res_src=0, flush_done=0, state=RUN, inflight=0, tag valids=0, last=1.
- Grant at cycle t → add at t+1 → sum sampled at t+1+ADD_LAT → res_valid at t+2+ADD_LAT.
- Throughput: one issue per cycle, back-to-back, alternating under contention.
- flush high at cycle t: no grant at t. With k issues in flight, flush_done rises the cycle after the last res_valid.
- flush high with nothing in flight: DRAIN at t+1, flush_done at t+2.
- Results emerge strictly in issue order.

## Test plan
- Reset: hold reset=0 with req0=req1=1 → all outputs 0, no grants; release → first grant gnt0 (last=1).
- Single: req0, a=1.0, b=2.0, row=5 at t → gnt0 at t, add=1 at t+1 with add0/add1/add_row=1.0/2.0/5; model sum=3.0 → res_valid at t+6 (ADD_LAT=4), res_value=3.0, res_row=5, res_src=0.
- Contention: req0, req1 held 6 cycles → grants 0,1,0,1,0,1; six consecutive res_valid with src 0,1,0,1,0,1 and matching rows.
- Flush drain: 3 issues in flight, raise flush → no further grants despite requests; flush_done rises the cycle after the 3rd res_valid; drop flush → arbitration resumes in RUN next cycle.
- Flush idle / short pulse: flush 1 cycle with inflight=0 → DRAIN, DONE, flush_done 1-cycle pulse, RUN.
- Async reset mid-drain: reset=0 with 2 in flight → outputs 0 immediately, no res_valid after release, inflight=0, state RUN.
